video_ditherer: RTL

VIDEO_DITHERER -- requirements
Module: video_ditherer

---
 rtl/video_ditherer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_ditherer.sv
// video_ditherer: ordered 4x4 dither from 8-bit to 5-bit colour per channel,
// re-expanded to 8 bits. Two-stage pipeline advanced by the pixel clock
// enable; timing signals are delayed by the same two strobes as the colour.
module video_ditherer #(
    parameter int TEMPORAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pixel,
    input  logic       enable,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       hblank_out,
    output logic       vblank_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out
);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Signed dither offset for a (row, effective column) matrix position.
    function automatic logic signed [3:0] offset_lut(input logic [1:0] row,
                                                     input logic [1:0] col);
        logic signed [3:0] off;
        case ({row, col})
            4'd0:    off = -4'sd4;
            4'd1:    off =  4'sd0;
            4'd2:    off = -4'sd3;
            4'd3:    off =  4'sd1;
            4'd4:    off =  4'sd2;
            4'd5:    off = -4'sd2;
            4'd6:    off =  4'sd3;
            4'd7:    off = -4'sd1;
            4'd8:    off = -4'sd3;
            4'd9:    off =  4'sd1;
            4'd10:   off = -4'sd4;
            4'd11:   off =  4'sd0;
            4'd12:   off =  4'sd3;
            4'd13:   off = -4'sd1;
            4'd14:   off =  4'sd2;
            4'd15:   off = -4'sd2;
            default: off =  4'sd0;
        endcase
        return off;
    endfunction

    // Add offset in 10-bit signed arithmetic, clamp to 0..255, keep the top
    // five bits and replicate their MSBs into the low bits so full scale
    // maps to 0xFF and zero to 0x00.
    function automatic logic [7:0] dither_chan(input logic [7:0]        c,
                                               input logic signed [3:0] off);
        logic signed [9:0] sum;
        logic [7:0]        clamped;
        logic [4:0]        q;
        sum = $signed({2'b00, c}) + $signed({{6{off[3]}}, off});
        if (sum[9]) begin
            clamped = 8'h00;
        end else if (sum[8]) begin
            clamped = 8'hFF;
        end else begin
            clamped = sum[7:0];
        end
        q = clamped[7:3];
        return {q, q[4:2]};
    endfunction

    // ------------------------------------------------------------------
    // Position counters and edge history
    // ------------------------------------------------------------------
    logic [1:0] r_x;
    logic [1:0] r_y;
    logic       r_frame;
    logic       r_hblank_d;
    logic       r_vblank_d;

    logic       w_active;
    logic       w_hblank_rise;
    logic       w_vblank_rise;
    logic [1:0] w_col;
    logic signed [3:0] w_offset;

    assign w_active      = ~hblank & ~vblank;
    assign w_hblank_rise = hblank & ~r_hblank_d;
    assign w_vblank_rise = vblank & ~r_vblank_d;

    // Effective column: temporal mode shifts the pattern by two on odd frames.
    always_comb begin
        w_col = r_x;
        if (TEMPORAL != 0) begin
            w_col = r_x + {r_frame, 1'b0};
        end else begin
            w_col = r_x;
        end
    end

    assign w_offset = offset_lut(r_y, w_col);

    // Column counter: cleared in horizontal blank, wraps silently mod 4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= 2'd0;
        end else if (ce_pixel) begin
            if (hblank) begin
                r_x <= 2'd0;
            end else if (w_active) begin
                r_x <= r_x + 2'd1;
            end else begin
                r_x <= r_x;
            end
        end else begin
            r_x <= r_x;
        end
    end

    // Row counter: cleared in vertical blank (wins over a same-strobe line
    // edge), otherwise steps on every start of horizontal blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y <= 2'd0;
        end else if (ce_pixel) begin
            if (vblank) begin
                r_y <= 2'd0;
            end else if (w_hblank_rise) begin
                r_y <= r_y + 2'd1;
            end else begin
                r_y <= r_y;
            end
        end else begin
            r_y <= r_y;
        end
    end

    // Frame parity toggles at each start of vertical blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame <= 1'b0;
        end else if (ce_pixel && w_vblank_rise) begin
            r_frame <= ~r_frame;
        end else begin
            r_frame <= r_frame;
        end
    end

    // Previous-strobe blank levels for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hblank_d <= 1'b0;
            r_vblank_d <= 1'b0;
        end else if (ce_pixel) begin
            r_hblank_d <= hblank;
            r_vblank_d <= vblank;
        end else begin
            r_hblank_d <= r_hblank_d;
            r_vblank_d <= r_vblank_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture colour, offset, enable, blank and timing
    // ------------------------------------------------------------------
    logic [7:0]        r_s1_red;
    logic [7:0]        r_s1_green;
    logic [7:0]        r_s1_blue;
    logic signed [3:0] r_s1_offset;
    logic              r_s1_enable;
    logic              r_s1_blank;
    logic [3:0]        r_s1_timing;

    // Stage 1 pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_red    <= 8'h00;
            r_s1_green  <= 8'h00;
            r_s1_blue   <= 8'h00;
            r_s1_offset <= 4'sd0;
            r_s1_enable <= 1'b0;
            r_s1_blank  <= 1'b0;
            r_s1_timing <= 4'h0;
        end else if (ce_pixel) begin
            r_s1_red    <= red;
            r_s1_green  <= green;
            r_s1_blue   <= blue;
            r_s1_offset <= w_offset;
            r_s1_enable <= enable;
            r_s1_blank  <= hblank | vblank;
            r_s1_timing <= {hblank, vblank, hsync, vsync};
        end else begin
            r_s1_red    <= r_s1_red;
            r_s1_green  <= r_s1_green;
            r_s1_blue   <= r_s1_blue;
            r_s1_offset <= r_s1_offset;
            r_s1_enable <= r_s1_enable;
            r_s1_blank  <= r_s1_blank;
            r_s1_timing <= r_s1_timing;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: clamp/quantise (or bypass / blank) and register outputs
    // ------------------------------------------------------------------
    logic [7:0] w_red_next;
    logic [7:0] w_green_next;
    logic [7:0] w_blue_next;

    // Select blanked, pass-through or dithered colour for stage 2.
    always_comb begin
        w_red_next   = 8'h00;
        w_green_next = 8'h00;
        w_blue_next  = 8'h00;
        if (r_s1_blank) begin
            w_red_next   = 8'h00;
            w_green_next = 8'h00;
            w_blue_next  = 8'h00;
        end else if (!r_s1_enable) begin
            w_red_next   = r_s1_red;
            w_green_next = r_s1_green;
            w_blue_next  = r_s1_blue;
        end else begin
            w_red_next   = dither_chan(r_s1_red,   r_s1_offset);
            w_green_next = dither_chan(r_s1_green, r_s1_offset);
            w_blue_next  = dither_chan(r_s1_blue,  r_s1_offset);
        end
    end

    logic [7:0] r_red_out;
    logic [7:0] r_green_out;
    logic [7:0] r_blue_out;
    logic [3:0] r_timing_out;

    // Stage 2 pipeline register driving every output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_red_out    <= 8'h00;
            r_green_out  <= 8'h00;
            r_blue_out   <= 8'h00;
            r_timing_out <= 4'h0;
        end else if (ce_pixel) begin
            r_red_out    <= w_red_next;
            r_green_out  <= w_green_next;
            r_blue_out   <= w_blue_next;
            r_timing_out <= r_s1_timing;
        end else begin
            r_red_out    <= r_red_out;
            r_green_out  <= r_green_out;
            r_blue_out   <= r_blue_out;
            r_timing_out <= r_timing_out;
        end
    end

    assign red_out    = r_red_out;
    assign green_out  = r_green_out;
    assign blue_out   = r_blue_out;
    assign hblank_out = r_timing_out[3];
    assign vblank_out = r_timing_out[2];
    assign hsync_out  = r_timing_out[1];
    assign vsync_out  = r_timing_out[0];

endmodule
